hdmi_axi_write_addr: RTL and testbench

//  Write-side address generator for the double-buffered DDR frame store. Paces AXI write

---
 rtl/hdmi_axi_write_addr.sv | 117 +++++++++++
 tb/tb_hdmi_axi_write_addr.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_axi_write_addr.sv
// Write-side burst address generator for the double-buffered frame store; publishes last completed bank.
// Latency: kick rises 2 cycles after fifo_count >= WORD_SIZE with busy low; frame_done 1 cycle after last burst accepted.
// Backpressure: waits for busy low before issuing, holds kick until busy seen high; early frame_start abandons the frame.
module hdmi_axi_write_addr #(
    parameter logic [31:0] X_SIZE      = 32'd256,
    parameter logic [31:0] Y_SIZE      = 32'd256,
    parameter logic [31:0] WORD_SIZE   = 32'd256,
    parameter logic [31:0] BANK_OFFSET = 32'h200_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [31:0] fifo_count,
    input  logic        busy,
    output logic        kick,
    output logic [31:0] write_addr,
    output logic [31:0] write_num,
    output logic        frame_select,
    output logic        frame_done,
    output logic        frame_err
);
    localparam logic [31:0] FRAME_SIZE  = X_SIZE * Y_SIZE;
    localparam logic [31:0] BURST_BYTES = WORD_SIZE * 32'd4;
    localparam logic [31:0] LAST_OFFSET = (FRAME_SIZE - WORD_SIZE) * 32'd4;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_DATA  = 3'd1,
        S_ISSUE_IDLE = 3'd2,
        S_ISSUE      = 3'd3,
        S_ISSUE_WAIT = 3'd4,
        S_FRAME_END  = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] wr_offset;
    logic        wr_bank;
    logic        start_pending;

    assign write_num  = WORD_SIZE;
    assign write_addr = wr_offset + (wr_bank ? BANK_OFFSET : 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            wr_offset     <= 32'd0;
            wr_bank       <= 1'b0;
            frame_select  <= 1'b1;
            kick          <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            start_pending <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start || start_pending) begin
                        start_pending <= 1'b0;
                        wr_offset     <= 32'd0;
                        state         <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (frame_start) begin
                        start_pending <= 1'b1;
                        frame_err     <= 1'b1;
                        state         <= S_IDLE;
                    end else if (fifo_count >= WORD_SIZE) begin
                        state <= S_ISSUE_IDLE;
                    end
                end
                S_ISSUE_IDLE: begin
                    if (frame_start) begin
                        start_pending <= 1'b1;
                        frame_err     <= 1'b1;
                        state         <= S_IDLE;
                    end else if (!busy) begin
                        kick  <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (frame_start) start_pending <= 1'b1;
                    state <= S_ISSUE_WAIT;
                end
                S_ISSUE_WAIT: begin
                    if (frame_start) start_pending <= 1'b1;
                    // The in-flight request must be seen by the master before any abort takes effect.
                    if (busy) begin
                        kick      <= 1'b0;
                        wr_offset <= wr_offset + BURST_BYTES;
                        if (wr_offset == LAST_OFFSET) begin
                            frame_done <= 1'b1;
                            state      <= S_FRAME_END;
                        end else if (start_pending || frame_start) begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_WAIT_DATA;
                        end
                    end
                end
                S_FRAME_END: begin
                    if (frame_start) start_pending <= 1'b1;
                    frame_select <= wr_bank;
                    wr_bank      <= ~wr_bank;
                    state        <= S_IDLE;
                end
                default: begin
                    kick  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hdmi_axi_write_addr.sv
// Randomized bench for hdmi_axi_write_addr: acts as AXI write master and compares bursts against a frame model.
module tb_hdmi_axi_write_addr;
    localparam logic [31:0] WORD_SIZE        = 32'd256;
    localparam logic [31:0] BANK_OFFSET      = 32'h200_0000;
    localparam int          BURSTS_PER_FRAME = 256 * 256 / 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [31:0] fifo_count;
    logic        busy;
    logic        kick;
    logic [31:0] write_addr;
    logic [31:0] write_num;
    logic        frame_select;
    logic        frame_done;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    // Reference model: which bank and burst index the next burst belongs to.
    int exp_bank;
    int exp_idx;
    int exp_select;
    int exp_done;
    int exp_err;

    hdmi_axi_write_addr dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .kick         (kick),
        .write_addr   (write_addr),
        .write_num    (write_num),
        .frame_select (frame_select),
        .frame_done   (frame_done),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_addr();
        return ((exp_bank != 0) ? BANK_OFFSET : 32'd0) + 32'(exp_idx) * (WORD_SIZE * 32'd4);
    endfunction

    task automatic model_accept(output bit completed);
        completed = 1'b0;
        exp_idx++;
        if (exp_idx == BURSTS_PER_FRAME) begin
            exp_idx    = 0;
            exp_done++;
            exp_select = exp_bank;
            exp_bank   = 1 - exp_bank;
            completed  = 1'b1;
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        exp_idx = 0;
    endtask

    // One burst as the AXI master: wait for kick, optionally abort or reset mid-handshake, accept with busy.
    task automatic do_burst(input int hold, input bit abort_if, input bit rst_if, input bit starve);
        int  n = 0;
        bit  completed;
        while (kick !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("kick_seen", {31'd0, kick}, 32'd1);
        if (kick !== 1'b1) return;
        check_val("burst_addr", write_addr, exp_addr());
        check_val("burst_num", write_num, WORD_SIZE);
        if (starve) fifo_count = 32'd0;
        frame_start = abort_if;
        @(negedge clk);
        frame_start = 1'b0;
        if (rst_if) begin
            rst = 1'b1;
            @(negedge clk);
            check_val("rst_kick", {31'd0, kick}, 32'd0);
            check_val("rst_addr", write_addr, 32'd0);
            check_val("rst_select", {31'd0, frame_select}, 32'd1);
            rst = 1'b0;
            exp_bank   = 0;
            exp_idx    = 0;
            exp_select = 1;
            return;
        end
        repeat ($urandom_range(0, 3)) begin
            check_val("kick_held", {31'd0, kick}, 32'd1);
            @(negedge clk);
        end
        busy = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("kick_low_busy", {31'd0, kick}, 32'd0);
        end
        busy = 1'b0;
        model_accept(completed);
        if (abort_if && !completed) begin
            exp_idx = 0;
            exp_err++;
        end
    endtask

    task automatic check_status(input string tag);
        repeat (4) @(negedge clk);
        check_val({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
        check_val({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
        check_val({tag, "_select"}, {31'd0, frame_select}, 32'(exp_select));
    endtask

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (frame_done === 1'b1 || frame_err === 1'b1)
            check_val("done_err_excl", {31'd0, frame_done & frame_err}, 32'd0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int kicks;
        rst         = 1'b1;
        frame_start = 1'b0;
        busy        = 1'b0;
        fifo_count  = 32'd0;
        exp_bank    = 0;
        exp_idx     = 0;
        exp_select  = 1;
        exp_done    = 0;
        exp_err     = 0;
        repeat (3) @(negedge clk);
        check_val("reset_kick", {31'd0, kick}, 32'd0);
        check_val("reset_select", {31'd0, frame_select}, 32'd1);
        check_val("reset_done", {31'd0, frame_done}, 32'd0);
        check_val("reset_err", {31'd0, frame_err}, 32'd0);
        check_val("reset_num", write_num, WORD_SIZE);
        check_val("reset_addr", write_addr, 32'd0);
        rst = 1'b0;

        // Two complete frames, bank 0 then bank 1.
        for (int f = 0; f < 2; f++) begin
            fifo_count = WORD_SIZE + 32'($urandom_range(0, 64));
            pulse_start();
            for (int b = 0; b < BURSTS_PER_FRAME; b++)
                do_burst($urandom_range(2, 5), 1'b0, 1'b0, 1'b0);
            check_status("frame");
        end

        // Just below burst size: nothing may issue.
        fifo_count = WORD_SIZE - 32'd1;
        pulse_start();
        kicks = 0;
        repeat (50) begin
            @(negedge clk);
            if (kick === 1'b1) kicks++;
        end
        check_val("starved_kicks", 32'(kicks), 32'd0);
        fifo_count = WORD_SIZE;
        @(negedge clk);
        check_val("kick_lat1", {31'd0, kick}, 32'd0);
        @(negedge clk);
        check_val("kick_lat2", {31'd0, kick}, 32'd1);
        do_burst(3, 1'b0, 1'b0, 1'b0);

        // Long busy from the previous burst keeps the next request back.
        do_burst(30, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 7; b++)
            do_burst($urandom_range(2, 5), 1'b0, 1'b0, 1'b0);
        do_burst(3, 1'b0, 1'b0, 1'b1);

        // Early frame_start while waiting for data.
        repeat (5) @(negedge clk);
        check_val("wait_data_kick", {31'd0, kick}, 32'd0);
        pulse_start();
        exp_err++;
        check_status("abort_wait");
        fifo_count = WORD_SIZE + 32'($urandom_range(0, 64));
        for (int b = 0; b < 4; b++)
            do_burst($urandom_range(2, 5), 1'b0, 1'b0, 1'b0);

        // Early frame_start during the handshake: in-flight burst completes, then restart.
        do_burst(3, 1'b1, 1'b0, 1'b0);
        do_burst(3, 1'b0, 1'b0, 1'b0);
        check_status("abort_inflight");

        // Run to the last burst and collide a frame_start with it: completion wins.
        for (int k = 0; k < 400 && exp_idx != BURSTS_PER_FRAME - 1; k++)
            do_burst($urandom_range(2, 4), 1'b0, 1'b0, 1'b0);
        do_burst(3, 1'b1, 1'b0, 1'b0);
        check_status("last_vs_abort");
        do_burst(3, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a handshake.
        do_burst(3, 1'b0, 1'b1, 1'b0);
        check_status("mid_rst");
        pulse_start();
        do_burst(3, 1'b0, 1'b0, 1'b0);
        check_status("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
